seven_seg_scanner: RTL
======================

Name: seven_seg_scanner

Overview:
Parametrised multiplexed driver for NUM_DIGITS seven-segment digits sharing one segment bus. It is the next generation of the single-digit BCD-to-seven-segment decoder with blank. Adds a latched display register, a prescaled digit-scan counter, leading-zero suppression and an invalid-code dash. Sits between datapath BCD results and the board's digit/segment pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned; must be >= 1.
PRESCALE, 1000, clock cycles each digit stays selected; must be >= 1, and 1 means advance every cycle.
LZ_BLANK, 1, 1 = suppress leading zeros, 0 = show all digits.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
bcd_in  input  4*NUM_DIGITS  BCD digits; [3:0] is digit 0 (least significant).
load  input  1  capture bcd_in into the display register.
blank_all  input  1  force all segments off.
segment  output  7  {g,f,e,d,c,b,a}, active-high, registered.
digit_en  output  NUM_DIGITS  one-hot digit select, active-high, registered.

Behaviour:
- One clock; reset is synchronous and active-high. Port names are clock and reset.
- Reset values: prescale counter = 0, digit index = 0, display register = all zeros, segment = 7'b0000000, digit_en = all zeros.
- Reset has priority over load and over every other input. Reset asserted mid-scan returns to the reset state on the next edge.
- Prescale counter: width $clog2(PRESCALE), minimum 1 bit. Counts 0..PRESCALE-1, then wraps to 0.
- Digit index advances when the counter wraps. Index goes from NUM_DIGITS-1 back to 0.
- Outputs are registered from the current index, so latency is 1 cycle.
- On the first edge after reset deasserts, digit_en = 1 << 0. Each digit is then held exactly PRESCALE cycles. A full frame is NUM_DIGITS*PRESCALE cycles.
- digit_en is exactly one-hot at all times except during reset and the first cycle after it.
- load = 1: the display register takes bcd_in at the edge. The new value appears on segment the cycle after the load edge if that digit is currently selected.
- With load = 0 the display register holds its value.
- Decode, per digit:
  - 0 → 0111111
  - 1 → 0000110
  - 2 → 1011011
  - 3 → 1001111
  - 4 → 1100110
  - 5 → 1101101
  - 6 → 1111101
  - 7 → 0000111
  - 8 → 1111111
  - 9 → 1101111
  - codes 10–15 → dash 1000000
- Leading-zero suppression (LZ_BLANK = 1): digit i > 0 is blanked (0000000) when it and every higher digit equal 4'd0.
  - Digit 0 is never suppressed.
  - Codes 10–15 count as nonzero.
- blank_all = 1: segment = 0000000 from the next edge. The scan counter and digit_en continue unchanged, with no phase disturbance.
- blank_all = 0 resumes decoded output the next edge.
- Priority for segment: reset > blank_all > leading-zero blank > decode.

Decomposition:
- Package seven_seg_pkg holds:
  - typedef seg_t (logic [6:0]);
  - constants SEG_BLANK and SEG_DASH;
  - the digit-0..9 segment constants.
- One combinational sub-module, bcd_to_seg (4-bit BCD → seg_t, dash on invalid), instantiated once on the muxed digit.
- Leading-zero mask is computed in the top as a NUM_DIGITS-bit vector from the display register.

Test Plan:
(All scenarios use NUM_DIGITS=4, PRESCALE=4, LZ_BLANK=1.)
1. Reset held 3 cycles, then released → segment = 0000000 and digit_en = 0000 during reset. digit_en = 0001 one edge after release, 0010 four cycles later, back to 0001 after 16 cycles.
2. load pulse with bcd_in = 16'h1234 → while 0001 selected segment = 1100110. Then 0010 → 1001111, 0100 → 1011011, 1000 → 0000110.
3. Load 16'h0070 → digits 3 and 2 = 0000000, digit 1 = 0000111, digit 0 = 0111111. Then load 16'h0000 → only digit 0 shows 0111111, others 0000000.
4. Load 16'h00F0 → digit 1 = 1000000 (dash). Digits 3 and 2 blanked, digit 0 = 0111111.
5. blank_all high for 10 cycles during scan of 16'h1234 → segment = 0000000 while digit_en keeps its 4-cycle rotation. After release, segments match scenario 2 for the selected digit.
6. reset and load (bcd_in = 16'h9999) asserted together mid-scan → reset state. After release, digit 0 shows 0111111 and digits 1–3 are blank, confirming the display register is 0.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared segment type and segment patterns for the seven-segment scanner.
package seven_seg_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned BCD_W = 4;

    // Segment bus ordering is {g,f,e,d,c,b,a}, active-high.
    typedef logic [SEG_W-1:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b000_0000;
    localparam seg_t SEG_DASH  = 7'b100_0000;

    localparam seg_t SEG_0 = 7'b011_1111;
    localparam seg_t SEG_1 = 7'b000_0110;
    localparam seg_t SEG_2 = 7'b101_1011;
    localparam seg_t SEG_3 = 7'b100_1111;
    localparam seg_t SEG_4 = 7'b110_0110;
    localparam seg_t SEG_5 = 7'b110_1101;
    localparam seg_t SEG_6 = 7'b111_1101;
    localparam seg_t SEG_7 = 7'b000_0111;
    localparam seg_t SEG_8 = 7'b111_1111;
    localparam seg_t SEG_9 = 7'b110_1111;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to seven-segment decoder; non-BCD codes show a dash.
module bcd_to_seg
    import seven_seg_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_i,
    output seg_t             seg_o
);

    // Digit lookup, dash for codes 10-15
    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment driver: latched display register, prescaled
// digit scan, leading-zero suppression and whole-display blanking.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned PRESCALE   = 1000,
    parameter bit          LZ_BLANK   = 1'b1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [BCD_W*NUM_DIGITS-1:0] bcd_in,
    input  logic                        load,
    input  logic                        blank_all,
    output seg_t                        segment,
    output logic [NUM_DIGITS-1:0]       digit_en
);

    localparam int unsigned CNT_W  = (PRESCALE   > 1) ? $clog2(PRESCALE)   : 1;
    localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned DISP_W = BCD_W * NUM_DIGITS;

    logic [CNT_W-1:0]      cnt_q,  cnt_d;
    logic [IDX_W-1:0]      idx_q,  idx_d;
    logic [DISP_W-1:0]     disp_q, disp_d;
    seg_t                  seg_q,  seg_d;
    logic [NUM_DIGITS-1:0] en_q,   en_d;

    logic [BCD_W-1:0]      cur_bcd;
    seg_t                  cur_seg;
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  zero_above;

    // Select the currently scanned digit from the display register
    always_comb begin
        cur_bcd = disp_q[32'(idx_q) * BCD_W +: BCD_W];
    end

    bcd_to_seg u_dec (
        .bcd_i (cur_bcd),
        .seg_o (cur_seg)
    );

    // Mark digits that are zero along with every higher digit; digit 0 stays lit
    always_comb begin
        lz_mask    = '0;
        zero_above = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
            zero_above = zero_above & (disp_q[i*BCD_W +: BCD_W] == 4'd0);
            lz_mask[i] = zero_above;
        end
    end

    // Next-state: prescale/scan counters, display latch, registered outputs
    always_comb begin
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        disp_d = disp_q;
        seg_d  = cur_seg;
        en_d   = NUM_DIGITS'(1) << idx_q;

        if (cnt_q == CNT_W'(PRESCALE - 1)) begin
            cnt_d = '0;
            if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (load) begin
            disp_d = bcd_in;
        end

        if (blank_all) begin
            seg_d = SEG_BLANK;
        end else if (LZ_BLANK && lz_mask[idx_q]) begin
            seg_d = SEG_BLANK;
        end
    end

    // State register with synchronous reset taking priority over all inputs
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            disp_q <= '0;
            seg_q  <= SEG_BLANK;
            en_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            disp_q <= disp_d;
            seg_q  <= seg_d;
            en_q   <= en_d;
        end
    end

    assign segment  = seg_q;
    assign digit_en = en_q;

endmodule
